// File: rtl/input_router_pkt.sv
// rtl/input_router_pkt.sv - packet-aware input router with per-VC route table and open-packet FSM
module input_router_pkt #(
  parameter int unsigned ROUTER_X_ID = 0,
  parameter int unsigned ROUTER_Y_ID = 0,
  parameter int unsigned N_VIRT_CHN  = 3,
  parameter int unsigned X_WIDTH     = 2,
  parameter int unsigned Y_WIDTH     = 2,
  parameter              ROUTING_ALG = "X_Y_ALG",
  parameter int unsigned REG_OUTPUT  = 0,
  localparam int unsigned VC_W = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  flit_valid_i,
  output logic                  flit_ready_o,
  input  logic [1:0]            flit_type_i,
  input  logic [VC_W-1:0]       vc_id_i,
  input  logic [X_WIDTH-1:0]    x_dest_i,
  input  logic [Y_WIDTH-1:0]    y_dest_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [4:0]            req_port_o,
  output logic [VC_W-1:0]       req_vc_o,
  output logic [N_VIRT_CHN-1:0] vc_busy_o,
  output logic                  route_err_o
);

  // One-hot output ports, bit0 = north
  localparam logic [4:0] P_NORTH = 5'b00001;
  localparam logic [4:0] P_SOUTH = 5'b00010;
  localparam logic [4:0] P_WEST  = 5'b00100;
  localparam logic [4:0] P_EAST  = 5'b01000;
  localparam logic [4:0] P_LOCAL = 5'b10000;

  localparam logic [1:0] T_HEAD      = 2'b00;
  localparam logic [1:0] T_BODY      = 2'b01;
  localparam logic [1:0] T_TAIL      = 2'b10;
  localparam logic [1:0] T_HEAD_TAIL = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OPEN = 1'b1;

  localparam logic [X_WIDTH-1:0] LP_X = X_WIDTH'(ROUTER_X_ID);
  localparam logic [Y_WIDTH-1:0] LP_Y = Y_WIDTH'(ROUTER_Y_ID);
  localparam bit YX_MODE = (ROUTING_ALG == "Y_X_ALG");

  logic [4:0]      r_route [N_VIRT_CHN];
  logic [0:0]      r_state [N_VIRT_CHN];
  logic            r_err;

  logic            w_flit_ready;
  logic            w_accept;
  logic            w_x_eq;
  logic            w_y_eq;
  logic            w_x_lt;
  logic            w_y_lt;
  logic [4:0]      w_new_route;
  logic            w_vc_ok;
  logic [0:0]      w_cur_state;
  logic [4:0]      w_cur_route;
  logic [4:0]      w_port;
  logic            w_err;
  logic            w_wr_route;
  logic [0:0]      w_nxt_state;

  assign w_x_eq   = (x_dest_i == LP_X);
  assign w_y_eq   = (y_dest_i == LP_Y);
  assign w_x_lt   = (x_dest_i <  LP_X);
  assign w_y_lt   = (y_dest_i <  LP_Y);
  assign w_vc_ok  = (int'(vc_id_i) < int'(N_VIRT_CHN));
  assign w_accept = flit_valid_i & w_flit_ready;

  // Dimension-order decode of the head flit destination
  always_comb begin
    w_new_route = P_LOCAL;
    if (w_x_eq && w_y_eq) begin
      w_new_route = P_LOCAL;
    end else if (YX_MODE) begin
      if (!w_y_eq) begin
        w_new_route = w_y_lt ? P_WEST : P_EAST;
      end else begin
        w_new_route = w_x_lt ? P_SOUTH : P_NORTH;
      end
    end else begin
      if (!w_x_eq) begin
        w_new_route = w_x_lt ? P_SOUTH : P_NORTH;
      end else begin
        w_new_route = w_y_lt ? P_WEST : P_EAST;
      end
    end
  end

  // Select the table entry and FSM state of the incoming flit's VC
  always_comb begin
    w_cur_state = ST_IDLE;
    w_cur_route = '0;
    for (int i = 0; i < int'(N_VIRT_CHN); i++) begin
      if (vc_id_i == VC_W'(i)) begin
        w_cur_state = r_state[i];
        w_cur_route = r_route[i];
      end
    end
  end

  // Per-VC open-packet FSM: decide route, error and table update for this flit
  always_comb begin
    w_port      = '0;
    w_err       = 1'b0;
    w_wr_route  = 1'b0;
    w_nxt_state = w_cur_state;
    if (!w_vc_ok) begin
      // Unknown VC: drain the flit and flag it, nothing to update
      w_err = 1'b1;
    end else if (w_cur_state == ST_IDLE) begin
      case (flit_type_i)
        T_HEAD: begin
          w_port      = w_new_route;
          w_wr_route  = 1'b1;
          w_nxt_state = ST_OPEN;
        end
        T_HEAD_TAIL: begin
          // Single-flit packet never opens the VC and leaves the table alone
          w_port = w_new_route;
        end
        default: begin
          // Orphan body/tail: accepted to avoid deadlock, routed nowhere
          w_err = 1'b1;
        end
      endcase
    end else begin
      case (flit_type_i)
        T_BODY: begin
          w_port = w_cur_route;
        end
        T_TAIL: begin
          w_port      = w_cur_route;
          w_nxt_state = ST_IDLE;
        end
        T_HEAD: begin
          // New head inside an open packet takes over the VC
          w_err       = 1'b1;
          w_port      = w_new_route;
          w_wr_route  = 1'b1;
          w_nxt_state = ST_OPEN;
        end
        default: begin
          w_err       = 1'b1;
          w_port      = w_new_route;
          w_wr_route  = 1'b1;
          w_nxt_state = ST_IDLE;
        end
      endcase
    end
  end

  // Route table and VC state update on input acceptance
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < int'(N_VIRT_CHN); i++) begin
        r_route[i] <= '0;
        r_state[i] <= ST_IDLE;
      end
    end else if (w_accept) begin
      for (int i = 0; i < int'(N_VIRT_CHN); i++) begin
        if (vc_id_i == VC_W'(i)) begin
          if (w_wr_route) begin
            r_route[i] <= w_new_route;
          end
          r_state[i] <= w_nxt_state;
        end
      end
    end
  end

  // Single-cycle protocol error pulse after the accepting handshake
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & w_err;
    end
  end

  assign route_err_o  = r_err;
  assign flit_ready_o = w_flit_ready;

  genvar g;
  for (g = 0; g < int'(N_VIRT_CHN); g++) begin : g_busy
    assign vc_busy_o[g] = (r_state[g] == ST_OPEN);
  end

  if (REG_OUTPUT == 0) begin : g_comb_out
    assign req_valid_o  = flit_valid_i;
    assign w_flit_ready = req_ready_i;
    assign req_port_o   = w_port;
    assign req_vc_o     = vc_id_i;
  end else begin : g_reg_out
    logic            r_valid;
    logic [4:0]      r_port;
    logic [VC_W-1:0] r_vc;

    assign w_flit_ready = !r_valid | req_ready_i;
    assign req_valid_o  = r_valid;
    assign req_port_o   = r_port;
    assign req_vc_o     = r_vc;

    // Output stage: load on acceptance, empty once the arbiter takes it
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        r_valid <= 1'b0;
        r_port  <= '0;
        r_vc    <= '0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_port  <= w_port;
        r_vc    <= vc_id_i;
      end else if (req_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
